// File: rtl/configuration_register_bank.sv
// Configuration register bank: masked read-modify-write, two registered read ports, a lockable
// low address region, change notification and a sequential clear engine for default values.
module configuration_register_bank #(
    parameter int unsigned           DATA_WIDTH      = 12,
    parameter int unsigned           ADDR_WIDTH      = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned           PROTECTED_DEPTH = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    input  logic                  lock_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_address_i,
    input  logic [DATA_WIDTH-1:0] write_mask_i,
    input  logic [DATA_WIDTH-1:0] data_input_i,
    output logic                  write_error_o,
    output logic                  change_o,
    output logic [ADDR_WIDTH-1:0] change_address_o,
    input  logic                  read_enable_a_i,
    input  logic [ADDR_WIDTH-1:0] read_address_a_i,
    output logic [DATA_WIDTH-1:0] data_output_a_o,
    output logic                  valid_a_o,
    input  logic                  read_enable_b_i,
    input  logic [ADDR_WIDTH-1:0] read_address_b_i,
    output logic [DATA_WIDTH-1:0] data_output_b_o,
    output logic                  valid_b_o
);

    localparam int unsigned            DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]    PROT_LIMIT = (ADDR_WIDTH + 1)'(PROTECTED_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StIdle  = 1'b1
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_count_next;

    // Storage has no reset; the clear engine provides the default contents.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_write_error;
    logic                  r_change;
    logic [ADDR_WIDTH-1:0] r_change_address;
    logic                  r_valid_a;
    logic                  r_valid_b;
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [DATA_WIDTH-1:0] r_data_b;

    logic                  w_busy;
    logic                  w_protected;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_changed;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_read_a;
    logic [DATA_WIDTH-1:0] w_read_b;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StClear;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // The exit on the last address wins over the natural counter wrap.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            StClear: begin
                w_count_next = r_count + 1'b1;
                if (r_count == LAST_ADDR) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                if (clear_i) begin
                    w_state_next = StClear;
                    w_count_next = '0;
                end
            end
            default: begin
                w_state_next = StClear;
                w_count_next = '0;
            end
        endcase
    end

    assign w_busy      = (r_state == StClear);
    assign w_protected = lock_i && ({1'b0, write_address_i} < PROT_LIMIT);
    assign w_accept    = write_enable_i && !w_busy && !clear_i && !w_protected;
    assign w_drop      = write_enable_i && !w_accept;
    assign w_old       = r_mem[write_address_i];
    assign w_merged    = (w_old & ~write_mask_i) | (data_input_i & write_mask_i);
    assign w_changed   = w_accept && (w_merged != w_old);

    always_ff @(posedge clock_i) begin
        if (w_busy) begin
            r_mem[r_count] <= RESET_VALUE;
        end else if (w_accept) begin
            r_mem[write_address_i] <= w_merged;
        end
    end

    // While clearing, every read reports the default value whatever the sweep position.
    always_comb begin
        w_read_a = r_mem[read_address_a_i];
        w_read_b = r_mem[read_address_b_i];
        if (w_busy) begin
            w_read_a = RESET_VALUE;
            w_read_b = RESET_VALUE;
        end else begin
            if (w_accept && (read_address_a_i == write_address_i)) begin
                w_read_a = w_merged;
            end
            if (w_accept && (read_address_b_i == write_address_i)) begin
                w_read_b = w_merged;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_write_error    <= 1'b0;
            r_change         <= 1'b0;
            r_change_address <= '0;
            r_valid_a        <= 1'b0;
            r_valid_b        <= 1'b0;
            r_data_a         <= '0;
            r_data_b         <= '0;
        end else begin
            r_write_error <= w_drop;
            r_change      <= w_changed;
            if (w_changed) begin
                r_change_address <= write_address_i;
            end
            r_valid_a <= read_enable_a_i;
            r_valid_b <= read_enable_b_i;
            if (read_enable_a_i) begin
                r_data_a <= w_read_a;
            end
            if (read_enable_b_i) begin
                r_data_b <= w_read_b;
            end
        end
    end

    assign busy_o           = w_busy;
    assign write_error_o    = r_write_error;
    assign change_o         = r_change;
    assign change_address_o = r_change_address;
    assign valid_a_o        = r_valid_a;
    assign valid_b_o        = r_valid_b;
    assign data_output_a_o  = r_data_a;
    assign data_output_b_o  = r_data_b;

endmodule

// File: tb/tb_configuration_register_bank.sv
// Scoreboard bench for configuration_register_bank: a behavioural model predicts read data,
// error and change pulses per edge; a negedge monitor pops and compares them.
module tb_configuration_register_bank;

    localparam int unsigned  DW     = 12;
    localparam int unsigned  AW     = 6;
    localparam int unsigned  DEPTH  = 64;
    localparam logic [DW-1:0] RV    = 12'h5A5;
    localparam int unsigned  PDEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          lock = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] mask = '0;
    logic [DW-1:0] din = '0;
    logic          re_a = 1'b0;
    logic          re_b = 1'b0;
    logic [AW-1:0] ra = '0;
    logic [AW-1:0] rb = '0;
    logic          busy;
    logic          werr;
    logic          chg;
    logic [AW-1:0] chg_addr;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_b;
    logic          val_a;
    logic          val_b;

    configuration_register_bank #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .RESET_VALUE    (RV),
        .PROTECTED_DEPTH(PDEPTH)
    ) u_dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .clear_i         (clr),
        .busy_o          (busy),
        .lock_i          (lock),
        .write_enable_i  (we),
        .write_address_i (waddr),
        .write_mask_i    (mask),
        .data_input_i    (din),
        .write_error_o   (werr),
        .change_o        (chg),
        .change_address_o(chg_addr),
        .read_enable_a_i (re_a),
        .read_address_a_i(ra),
        .data_output_a_o (dout_a),
        .valid_a_o       (val_a),
        .read_enable_b_i (re_b),
        .read_address_b_i(rb),
        .data_output_b_o (dout_b),
        .valid_b_o       (val_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   edge_n;
        logic [DW-1:0] val;
    } exp_t;

    // Channels: 0 read A, 1 read B, 2 write error pulse, 3 change pulse (value = address).
    exp_t        sb [4][$];
    string       ch_name [4] = '{"read_a", "read_b", "write_error", "change"};
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned edge_cnt = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            model_left = DEPTH;  // clearing edges still to come

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] addr, input bit is_busy,
                                                  input bit acc, input logic [DW-1:0] nv);
        if (is_busy) return RV;
        if (acc && addr == waddr) return nv;
        return model_mem[addr];
    endfunction

    // Predict the outcome of the coming edge from the current inputs, then advance the model.
    task automatic cycle();
        bit            live;
        bit            is_busy;
        bit            prot;
        bit            acc;
        logic [DW-1:0] oldv;
        logic [DW-1:0] nv;
        int unsigned   nx;
        live    = !rst;
        nx      = edge_cnt + 1;
        is_busy = model_left > 0;
        prot    = lock && (int'(waddr) < int'(PDEPTH));
        acc     = we && !is_busy && !clr && !prot;
        oldv    = model_mem[waddr];
        nv      = (oldv & ~mask) | (din & mask);
        if (live) begin
            if (we && !acc) sb[2].push_back('{edge_n: nx, val: '0});
            if (acc && nv != oldv) sb[3].push_back('{edge_n: nx, val: DW'(waddr)});
            if (re_a) sb[0].push_back('{edge_n: nx, val: expect_read(ra, is_busy, acc, nv)});
            if (re_b) sb[1].push_back('{edge_n: nx, val: expect_read(rb, is_busy, acc, nv)});
        end
        @(posedge clk);
        if (live) begin
            if (acc) model_mem[waddr] = nv;
            if (is_busy) begin
                model_left--;
                if (model_left == 0) begin
                    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = RV;
                end
            end else if (clr) begin
                model_left = DEPTH;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic          fired [4];
        logic [DW-1:0] act [4];
        fired[0] = val_a;  act[0] = dout_a;
        fired[1] = val_b;  act[1] = dout_b;
        fired[2] = werr;   act[2] = '0;
        fired[3] = chg;    act[3] = DW'(chg_addr);
        n_cmp++;
        if (busy !== (model_left > 0)) begin
            n_bad++;
            $display("FAIL busy at edge %0d: got %b, expected %b", edge_cnt, busy, model_left > 0);
        end
        for (int ch = 0; ch < 4; ch++) begin
            while (sb[ch].size() > 0 && sb[ch][0].edge_n < edge_cnt) begin
                n_cmp++;
                n_bad++;
                e = sb[ch].pop_front();
                $display("FAIL %s: no output at edge %0d, expected 0x%0h", ch_name[ch], e.edge_n,
                         e.val);
            end
            if (fired[ch]) begin
                n_cmp++;
                if (sb[ch].size() == 0 || sb[ch][0].edge_n != edge_cnt) begin
                    n_bad++;
                    $display("FAIL %s: unexpected output 0x%0h at edge %0d, expected none",
                             ch_name[ch], act[ch], edge_cnt);
                end else begin
                    e = sb[ch].pop_front();
                    if (act[ch] !== e.val) begin
                        n_bad++;
                        $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", ch_name[ch],
                                 edge_cnt, act[ch], e.val);
                    end
                end
            end
        end
    end

    task automatic set_idle();
        clr = 0; we = 0; re_a = 0; re_b = 0; lock = 0;
    endtask

    task automatic do_reset(input int hold);
        set_idle();
        rst = 1;
        for (int ch = 0; ch < 4; ch++) sb[ch].delete();
        model_left = DEPTH;
        #1;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_write_error", 32'(werr), 0);
        chk("rst_change", 32'(chg), 0);
        chk("rst_change_addr", 32'(chg_addr), 0);
        chk("rst_valid_a", 32'(val_a), 0);
        chk("rst_valid_b", 32'(val_b), 0);
        chk("rst_data_a", 32'(dout_a), 0);
        chk("rst_data_b", 32'(dout_b), 0);
        repeat (hold) cycle();
        rst = 0;
    endtask

    task automatic count_busy(input string name, input int exp);
        int n;
        n = 0;
        while (busy && n < 200) begin
            cycle();
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        we = 1; waddr = a; din = d; mask = m;
        cycle();
        we = 0;
    endtask

    task automatic rd(input bit pa, input logic [AW-1:0] aa, input bit pb, input logic [AW-1:0] ab);
        re_a = pa; ra = aa; re_b = pb; rb = ab;
        cycle();
        re_a = 0; re_b = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up clear.
        do_reset(3);
        count_busy("reset_clear_len", DEPTH);
        rd(1, 0, 0, 0);
        rd(1, 63, 0, 0);
        cycle();

        // Masked writes and change notification.
        wr(5, 12'hABC, 12'hFFF);
        wr(5, 12'h123, 12'h0F0);
        rd(0, 0, 1, 5);
        chk("change_addr_5", 32'(chg_addr), 5);
        wr(5, 12'hA2C, 12'hFFF);
        cycle();

        // Lock protection boundary.
        lock = 1;
        wr(3, 12'h111, 12'hFFF);
        chk("lock_error_pulse", 32'(werr), 1);
        wr(8, 12'h111, 12'hFFF);
        chk("unlocked_addr8_no_error", 32'(werr), 0);
        rd(1, 3, 1, 8);
        lock = 0;
        wr(3, 12'h111, 12'hFFF);
        rd(1, 3, 0, 0);

        // Write-first bypass on both ports.
        we = 1; waddr = 10; din = 12'h7FF; mask = 12'hFFF;
        re_a = 1; ra = 10; re_b = 1; rb = 10;
        cycle();
        set_idle();
        chk("bypass_valid_a", 32'(val_a), 1);
        chk("bypass_valid_b", 32'(val_b), 1);
        cycle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            we    = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 149) == 0);
            lock  = 1'($urandom_range(0, 1));
            waddr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            din   = DW'($urandom);
            case ($urandom_range(0, 3))
                0:       mask = '1;
                1:       mask = '0;
                default: mask = DW'($urandom);
            endcase
            re_a = 1'($urandom_range(0, 1));
            re_b = 1'($urandom_range(0, 1));
            ra   = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 15));
            rb   = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 15));
            cycle();
        end
        set_idle();
        for (int i = 0; i < 100 && busy; i++) cycle();

        // Clear colliding with a write, then a write while busy.
        wr(2, 12'h3C3, 12'hFFF);
        clr = 1; we = 1; waddr = 2; din = 12'h0F0; mask = 12'hFFF;
        cycle();
        clr = 0;
        chk("collision_error_pulse", 32'(werr), 1);
        waddr = 7;
        cycle();
        we = 0;
        chk("busy_write_error_pulse", 32'(werr), 1);
        count_busy("soft_clear_len", DEPTH - 1);
        rd(1, 2, 1, 7);

        // Reset in the middle of a clear, with reads in flight.
        clr = 1;
        cycle();
        clr = 0;
        repeat (19) cycle();
        rd(1, 4, 1, 9);
        chk("pre_reset_valid_a", 32'(val_a), 1);
        do_reset(2);
        count_busy("reset_midclear_len", DEPTH);
        rd(1, 5, 1, 63);

        set_idle();
        repeat (3) cycle();
        for (int ch = 0; ch < 4; ch++) chk({ch_name[ch], "_drained"}, 32'(sb[ch].size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/configuration_register_bank.md
# configuration_register_bank

Parametrised configuration register file for NoC interface blocks. It provides masked (read-modify-write) writes, two independent registered read ports with valid flags, a write-protected low address region, and change notification. Because the storage array has no per-entry reset, a sequential clear engine fills every entry with `RESET_VALUE` after reset or on request. It replaces the single-port, combinational-read register file in NoC interfaces that need default values and multiple readers.

## Interface
- `DATA_WIDTH`, 12: width of each entry.
- `ADDR_WIDTH`, 6: address bits; depth is `DEPTH = 2**ADDR_WIDTH`.
- `RESET_VALUE`, 0: value loaded into every entry by the clear engine.
- `PROTECTED_DEPTH`, 8: addresses `0..PROTECTED_DEPTH-1` are write-protected while `lock_i`=1. Legal range is 0..DEPTH.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `clear_i` in 1: one-cycle request to start a soft clear.
- `busy_o` out 1: clear engine running.
- `lock_i` in 1: level input that enables protection of the low region.
- `write_enable_i` in 1: write request.
- `write_address_i` in ADDR_WIDTH: write address.
- `write_mask_i` in DATA_WIDTH: per-bit write mask.
- `data_input_i` in DATA_WIDTH: write data.
- `write_error_o` out 1: one-cycle pulse when a write is dropped.
- `change_o` out 1: one-cycle pulse when a stored value changed.
- `change_address_o` out ADDR_WIDTH: address of the last change.
- `read_enable_a_i` / `read_enable_b_i` in 1: read requests.
- `read_address_a_i` / `read_address_b_i` in ADDR_WIDTH: read addresses.
- `data_output_a_o` / `data_output_b_o` out DATA_WIDTH: registered read data.
- `valid_a_o` / `valid_b_o` out 1: read data valid.

## Operation
- **FSM states**
  - `CLEAR`: clear engine active.
  - `IDLE`: normal operation.
- **Reset behaviour**
  - `reset_i`=1 forces `CLEAR` with clear counter = 0.
  - Reset values: `busy_o`=1, `write_error_o`=0, `change_o`=0, `change_address_o`=0, `valid_a_o`/`valid_b_o`=0, `data_output_a_o`/`data_output_b_o`=0.
- **CLEAR state**
  - Each cycle writes `RESET_VALUE` to entry[counter], then increments the counter.
  - After the cycle with counter = DEPTH-1, the FSM moves to `IDLE` and `busy_o` goes to 0.
  - `clear_i` is ignored; the counter is not restarted.
- **IDLE state**
  - `clear_i`=1 moves the FSM to `CLEAR` with counter = 0.
  - If `clear_i`=1 coincides with `write_enable_i`=1, clear wins: the write is dropped and `write_error_o` pulses.
- **Write acceptance**
  - A write is accepted when the FSM is in `IDLE`, `clear_i`=0, and the address is not protected.
  - Protected means `lock_i`=1 and `write_address_i` < `PROTECTED_DEPTH`.
- **Write merge**
  - The stored value becomes `new = (old & ~write_mask_i) | (data_input_i & write_mask_i)`.
  - A mask of all zeros is accepted but leaves the entry unchanged.
- **Dropped writes**
  - A write is dropped when the FSM is in `CLEAR`, the address is protected, or clear wins.
  - Every dropped write produces a `write_error_o` pulse in the following cycle.
- **Change notification**
  - An accepted write with `new != old` pulses `change_o` in the following cycle.
  - `change_address_o` is loaded with the write address at the same time and holds until the next change.
  - Clear-engine writes never raise `change_o`.
- **Reads**
  - Each port works independently.
  - `read_enable`=1 at an edge → data and valid=1 at that edge; valid=0 otherwise, and data holds its previous value.
  - Both ports may read the same address.
- **Read-during-write**
  - A read of the address being written by an accepted write in the same cycle returns the merged new value (write-first bypass).
- **Read while busy**
  - A read issued while `busy_o`=1 returns `RESET_VALUE` with valid=1, regardless of how far the clear has progressed.

## Timing
- **Read latency**: 1 cycle. Request sampled at edge N; data and valid visible after edge N, i.e. during cycle N+1.
- **Write visibility**
  - Via the bypass: in the same cycle.
  - Via a normal read: from the next edge.
- **Clear duration**: exactly DEPTH cycles from the first edge after reset release or after `clear_i` is accepted. `busy_o` falls after the DEPTH-th edge.
- **Write acceptance while clearing**: the first accepted write is at the edge where `busy_o` was sampled 0.
- **Pulse timing**: `write_error_o` and `change_o` are high for exactly one cycle, registered one edge after the causing request.
- **Reset mid-clear**: the counter restarts at 0 and a full DEPTH-cycle clear is repeated.
- **Reset mid-read**: the valid flags drop immediately.
- **Counter width**: the counter is ADDR_WIDTH bits and wraps from DEPTH-1; the state transition on reaching DEPTH-1 takes precedence over the wrap.

## Test plan
- **Reset clear**: ADDR_WIDTH=6, RESET_VALUE=0x5A5; release reset → `busy_o`=1 for exactly 64 cycles. Then reading addr 0 and addr 63 on port A returns 0x5A5 with `valid_a_o`=1 one cycle after the request.
- **Masked writes**: write 0xABC mask 0xFFF to addr 5, then 0x123 mask 0x0F0 to addr 5 → port B reads 0xA2C. `change_o` pulses twice with `change_address_o`=5. Rewriting 0xA2C mask 0xFFF → no `change_o` pulse.
- **Lock**: `lock_i`=1, PROTECTED_DEPTH=8; write 0x111 to addr 3 → `write_error_o` pulses and addr 3 keeps its old value. Write 0x111 to addr 8 → accepted, no error. With `lock_i`=0, the write to addr 3 succeeds.
- **Bypass**: write 0x7FF mask 0xFFF to addr 10 while both ports read addr 10 in the same cycle → both ports return 0x7FF the next cycle with both valid flags=1.
- **Clear collision**: `clear_i` and a write to addr 2 in the same IDLE cycle → write dropped, `write_error_o` pulses, `busy_o` high 64 cycles. A write issued during busy → error pulse. Addr 2 reads RESET_VALUE afterwards.
- **Reset mid-clear**: assert `reset_i` at clear count 20 → outputs return to their reset values immediately, and a full 64-cycle clear follows the release.
